riscv_test_monitor: RTL and testbench

- Synthesizable pass/fail monitor for the riscv-tests regression.
- Replaces the fixed-tick check "gp == 1 after N cycles" with one that stops on the first completion event and reports its cause:
  - a store to the tohost address,
  - a gp-register check when the core reaches ecall,
  - a watchdog timeout.
- Sits beside Core in each test top. Observes the core's store bus, gp and retire signals. Exposes sticky status for the bench to log and $finish on.

---
 rtl/riscv_test_pkg.sv | 36 +++
 rtl/test_watchdog_counter.sv | 42 ++++
 rtl/riscv_test_monitor.sv | 173 +++++++++++++++++
 tb/tb_riscv_test_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_test_pkg.sv
// Shared definitions for the riscv-tests pass/fail monitor.
//   state_e             : monitor state, value doubles as the status output encoding
//   result_e            : classification of a tohost / gp result word
//   DEFAULT_TOHOST_ADDR : byte address of the tohost word
//   decode_result()     : value -> pass / fail / ignore (testnum is value >> 1)
package riscv_test_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ResIgnore = 2'd0,
        ResPass   = 2'd1,
        ResFail   = 2'd2
    } result_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

    // riscv-tests convention: 1 = pass, odd != 1 = fail with testnum in
    // the upper bits, even = not a result word.
    function automatic result_e decode_result(input logic [63:0] value);
        if (value == 64'd1) begin
            return ResPass;
        end else if (value[0]) begin
            return ResFail;
        end else begin
            return ResIgnore;
        end
    endfunction

endpackage

// File: rtl/test_watchdog_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count compare.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : zero the count (wins over enable)
//   enable        : increment by one, holding at all-ones
//   count         : current count
//   at_terminal   : count equals TERMINAL
module test_watchdog_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TERMINAL = 4999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count       = count_q;
    assign at_terminal = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests: stops on the first completion event
// (tohost store, ecall with gp check, or watchdog timeout) and holds the result.
// Optional macro RISCV_TEST_MONITOR_SELFLOOP_EN adds a stuck-pc detector that
// is evaluated like an ecall (non-result gp -> TIMEOUT).
//   clk, rst                : clock, asynchronous active-low reset
//   start, clear            : run pulse, sticky-status clear (clear wins)
//   st_valid/st_addr/st_data: observed core store bus
//   ecall_retire, gp_value  : ecall retirement and current x3
//   pc                      : retire pc (self-loop detector only)
//   done/pass/timeout       : decoded from state
//   fail_testnum            : failing test number, 0 unless FAIL
//   cycle_count             : RUN cycles elapsed, frozen on done
//   status                  : encoded state
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR),
    parameter int unsigned     TIMEOUT_CYCLES = 5000,
    parameter int unsigned     CNT_W          = 32,
    parameter logic [1:0]      DETECT_MODE    = 2'b11
`ifdef RISCV_TEST_MONITOR_SELFLOOP_EN
    ,
    parameter int unsigned     LOOP_CYCLES    = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    input  logic             ecall_retire,
    input  logic [XLEN-1:0]  gp_value,
    input  logic [XLEN-1:0]  pc,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-2:0]  fail_testnum,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       status
);

    state_e          state_q, state_d;
    logic [XLEN-2:0] fail_q, fail_d;

    logic    cnt_clr, cnt_en, timeout_hit;
    result_e tohost_kind, gp_kind;
    logic    tohost_evt, ecall_evt, loop_evt;

    assign tohost_kind = decode_result(64'(st_data));
    assign gp_kind     = decode_result(64'(gp_value));

    // Even tohost words and non-result gp values are not events at all, so a
    // lower-priority source may still end the test in that cycle.
    assign tohost_evt = DETECT_MODE[0] && st_valid && (st_addr == TOHOST_ADDR)
                        && (tohost_kind != ResIgnore);
    assign ecall_evt  = DETECT_MODE[1] && ecall_retire && (gp_kind != ResIgnore);

    test_watchdog_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (cnt_clr),
        .enable      (cnt_en),
        .count       (cycle_count),
        .at_terminal (timeout_hit)
    );

`ifdef RISCV_TEST_MONITOR_SELFLOOP_EN
    localparam int unsigned LOOP_W = $clog2(LOOP_CYCLES) + 1;

    logic [XLEN-1:0]   pc_q;
    logic              pc_same, loop_term, loop_run;
    logic [LOOP_W-1:0] loop_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc;
        end
    end

    assign pc_same  = (pc == pc_q);
    assign loop_run = (state_q == StRun);

    // Counts consecutive RUN edges with an unchanged pc; any pc change restarts it.
    test_watchdog_counter #(
        .WIDTH    (LOOP_W),
        .TERMINAL (LOOP_CYCLES - 1)
    ) u_loop_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (!loop_run || !pc_same || start || clear),
        .enable      (loop_run && pc_same),
        .count       (loop_count),
        .at_terminal (loop_term)
    );

    assign loop_evt = loop_run && pc_same && loop_term;
`else
    assign loop_evt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (clear) begin
            state_d = StIdle;
            fail_d  = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                        cnt_clr = 1'b1;
                    end
                end
                StRun: begin
                    if (start) begin
                        cnt_clr = 1'b1;
                    end else if (tohost_evt) begin
                        state_d = (tohost_kind == ResPass) ? StPass : StFail;
                        if (tohost_kind == ResFail) fail_d = st_data[XLEN-1:1];
                    end else if (ecall_evt) begin
                        state_d = (gp_kind == ResPass) ? StPass : StFail;
                        if (gp_kind == ResFail) fail_d = gp_value[XLEN-1:1];
                    end else if (loop_evt) begin
                        unique case (gp_kind)
                            ResPass: state_d = StPass;
                            ResFail: begin
                                state_d = StFail;
                                fail_d  = gp_value[XLEN-1:1];
                            end
                            default: state_d = StTimeout;
                        endcase
                    end else if (timeout_hit) begin
                        state_d = StTimeout;
                    end else begin
                        // Counter only advances while the test keeps running,
                        // so it reads the count at the completing edge.
                        cnt_en = 1'b1;
                    end
                end
                default: ; // terminal states hold until clear or reset
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
        end
    end

    assign status       = state_q;
    assign pass         = (state_q == StPass);
    assign timeout      = (state_q == StTimeout);
    assign done         = (state_q == StPass) || (state_q == StFail) || (state_q == StTimeout);
    assign fail_testnum = fail_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst, start, clear, st_valid, ecall_retire;
    logic [31:0] st_addr, st_data, gp_value, pc;
    logic        done, pass, timeout;
    logic [30:0] fail_testnum;
    logic [31:0] cycle_count;
    logic [2:0]  status;
    logic        pc_hold;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  st;
        logic [30:0] tn;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    riscv_test_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear        (clear),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .ecall_retire (ecall_retire),
        .gp_value     (gp_value),
        .pc           (pc),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .fail_testnum (fail_testnum),
        .cycle_count  (cycle_count),
        .status       (status)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_addr  = addr;
        st_data  = data;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    task automatic ecall(input logic [31:0] gp);
        ecall_retire = 1'b1;
        gp_value     = gp;
        @(negedge clk);
        ecall_retire = 1'b0;
    endtask

    task automatic push(input logic [2:0] st, input logic [30:0] tn, input logic [31:0] cnt);
        exp_t e;
        e.st  = st;
        e.tn  = tn;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done, then compares against the oldest expectation.
    task automatic wait_done(input string tag, input int budget);
        exp_t e;
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_status"}, 64'(status), 64'(e.st));
            check({tag, "_pass"}, 64'(pass), 64'(e.st == 3'd2));
            check({tag, "_timeout"}, 64'(timeout), 64'(e.st == 3'd4));
            check({tag, "_testnum"}, 64'(fail_testnum), 64'(e.tn));
            check({tag, "_count"}, 64'(cycle_count), 64'(e.cnt));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_status"}, 64'(status), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_testnum"}, 64'(fail_testnum), 64'd0);
        check({tag, "_count"}, 64'(cycle_count), 64'd0);
    endtask

    // pc walks unless held, so the self-loop detector never fires by accident.
    initial begin
        forever begin
            @(negedge clk);
            if (!pc_hold) pc = pc + 32'd4;
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; clear = 1'b0; st_valid = 1'b0; ecall_retire = 1'b0;
        st_addr = '0; st_data = '0; gp_value = '0; pc = 32'h100; pc_hold = 1'b0;
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Pass via tohost at count 20
        pulse_start();
        check("run_status", 64'(status), 64'd1);
        check("run_count0", 64'(cycle_count), 64'd0);
        cycles(20);
        check("run_count20", 64'(cycle_count), 64'd20);
        push(3'd2, 31'd0, 32'd20);
        store(32'h1000, 32'h1);
        wait_done("tohost_pass", 4);
        // Terminal state ignores start, stores and ecalls
        start = 1'b1;
        store(32'h1000, 32'h7);
        start = 1'b0;
        ecall(32'h3);
        cycles(3);
        check("sticky_status", 64'(status), 64'd2);
        check("sticky_count", 64'(cycle_count), 64'd20);

        // Fail via tohost
        pulse_clear();
        check_zero("clear1");
        pulse_start();
        push(3'd3, 31'd3, 32'd0);
        store(32'h1000, 32'h7);
        wait_done("tohost_fail", 4);

        // Even tohost word ignored, then ecall gp=1 passes
        pulse_clear();
        pulse_start();
        store(32'h1000, 32'h4);
        check("even_ignored", 64'(status), 64'd1);
        ecall(32'h4);
        check("even_gp_ignored", 64'(status), 64'd1);
        push(3'd2, 31'd0, 32'd2);
        ecall(32'h1);
        wait_done("ecall_pass", 4);

        // Ecall fail, testnum 5
        pulse_clear();
        pulse_start();
        push(3'd3, 31'd5, 32'd0);
        ecall(32'hb);
        wait_done("ecall_fail", 4);

        // Start in RUN restarts the counter
        pulse_clear();
        pulse_start();
        cycles(5);
        check("restart_pre", 64'(cycle_count), 64'd5);
        pulse_start();
        check("restart_count", 64'(cycle_count), 64'd0);
        check("restart_status", 64'(status), 64'd1);

        // Store to wrong address, then timeout
        pulse_clear();
        pulse_start();
        push(3'd4, 31'd0, 32'd4999);
        store(32'h1004, 32'h1);
        wait_done("timeout", 5100);

        // Same-cycle tohost fail and ecall pass: tohost wins
        pulse_clear();
        pulse_start();
        cycles(3);
        push(3'd3, 31'd2, 32'd3);
        st_valid = 1'b1; st_addr = 32'h1000; st_data = 32'h5;
        ecall_retire = 1'b1; gp_value = 32'h1;
        @(negedge clk);
        st_valid = 1'b0; ecall_retire = 1'b0;
        wait_done("priority", 4);
        pulse_clear();
        check_zero("clear2");

        // Clear beats a same-cycle tohost pass
        pulse_start();
        clear = 1'b1;
        store(32'h1000, 32'h1);
        clear = 1'b0;
        check_zero("clear_wins");

        // Asynchronous reset mid-RUN
        pulse_start();
        cycles(6);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        store(32'h1000, 32'h1);
        ecall(32'h1);
        check_zero("idle_ignores");

`ifdef RISCV_TEST_MONITOR_SELFLOOP_EN
        pc_hold = 1'b1;
        pc = 32'h40;
        gp_value = 32'h1;
        pulse_start();
        cycles(20);
        check("loop_pass", 64'(status), 64'd2);
        pulse_clear();
        gp_value = 32'h0;
        pulse_start();
        cycles(20);
        check("loop_timeout", 64'(status), 64'd4);
        pulse_clear();
        pc_hold = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
